// File: rtl/eth_fcs_sequencer_if.sv
// Byte-stream handshake bundle around the FCS sequencer: payload in, framed bytes out.
// The slave side is the sequencer; the master side is the MAC source plus PCS sink.
interface eth_fcs_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/eth_fcs_sequencer.sv
// Appends the Ethernet FCS to a MAC TX byte stream: pass-through, zero-pad to MIN_LEN, 4 FCS bytes.
// A single registered CRC-32 byte engine is sequenced; its result is captured only after a handshake.

// Free-running CRC-32 byte engine (one-cycle latency); serial bit 0 of d is consumed first.
module next_crc32_d8 (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_port,
  input  logic [7:0]  d,
  input  logic [31:0] crc_port,
  output logic [31:0] return_port,
  output logic        done_port
);
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

  function automatic logic [31:0] crc32_d8(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      return_port <= '0;
      done_port   <= 1'b0;
    end else begin
      done_port <= start_port;
      if (start_port) return_port <= crc32_d8(crc_port, d);
    end
  end
endmodule

module eth_fcs_sequencer #(
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned CNT_W   = 11
) (
  input  logic                  clock,
  input  logic                  reset,
  eth_fcs_sequencer_if.slave    bus,
  output logic                  busy,
  output logic [31:0]           fcs_value,
  output logic                  fcs_done
);
  localparam logic [31:0]      CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAD,
    ST_FCS
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_sat;
  logic [31:0]      cnt_inc;
  logic [1:0]       fcs_idx;
  logic [1:0]       fcs_idx_nxt;
  logic [31:0]      crc_q;
  logic [31:0]      crc_ret;
  logic [31:0]      crc_eff;
  logic [31:0]      crc_in;
  logic [7:0]       fcs_byte;
  logic             upd_pend;
  logic             out_hs_c;
  logic             fcs_fire_c;
  logic             engine_done_unused;

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // The engine result is only fresh the cycle after a handshake; otherwise the held copy is used.
  assign crc_eff = upd_pend ? crc_ret : crc_q;
  assign crc_in  = (state == ST_IDLE) ? CRC_INIT : crc_eff;
  assign cnt_inc = 32'(cnt) + 32'd1;
  assign cnt_sat = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign busy    = (state != ST_IDLE);

  next_crc32_d8 u_crc (
    .clock       (clock),
    .reset       (reset),
    .start_port  (1'b1),
    .d           (bus.out_data),
    .crc_port    (crc_in),
    .return_port (crc_ret),
    .done_port   (engine_done_unused)
  );

  // FCS byte k is taken MSB-byte first from the effective register, reflected and inverted.
  always_comb begin
    fcs_byte = crc_eff[31:24];
    case (fcs_idx)
      2'd0:    fcs_byte = crc_eff[31:24];
      2'd1:    fcs_byte = crc_eff[23:16];
      2'd2:    fcs_byte = crc_eff[15:8];
      default: fcs_byte = crc_eff[7:0];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    fcs_idx_nxt   = fcs_idx;
    out_hs_c      = 1'b0;
    fcs_fire_c    = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = bus.in_data;
    case (state)
      ST_IDLE, ST_DATA: begin
        bus.in_ready  = bus.out_ready & ~reset;
        bus.out_valid = bus.in_valid & ~reset;
        out_hs_c      = bus.in_valid & bus.out_ready & ~reset;
        if (out_hs_c) begin
          cnt_nxt = cnt_sat;
          if (!bus.in_last)          state_nxt = ST_DATA;
          else if (cnt_inc < MIN_LEN) state_nxt = ST_PAD;
          else                       state_nxt = ST_FCS;
        end
      end
      ST_PAD: begin
        bus.out_data  = 8'h00;
        bus.out_valid = ~reset;
        out_hs_c      = bus.out_ready & ~reset;
        if (out_hs_c) begin
          cnt_nxt = cnt_sat;
          if (cnt_inc >= MIN_LEN) state_nxt = ST_FCS;
        end
      end
      default: begin
        bus.out_data  = ~bitrev8(fcs_byte);
        bus.out_valid = ~reset;
        bus.out_last  = (fcs_idx == 2'd3);
        out_hs_c      = bus.out_ready & ~reset;
        if (out_hs_c) begin
          if (fcs_idx == 2'd3) begin
            state_nxt   = ST_IDLE;
            cnt_nxt     = '0;
            fcs_idx_nxt = 2'd0;
            fcs_fire_c  = 1'b1;
          end else begin
            fcs_idx_nxt = fcs_idx + 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      fcs_idx   <= 2'd0;
      crc_q     <= '0;
      upd_pend  <= 1'b0;
      fcs_value <= '0;
      fcs_done  <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      fcs_idx  <= fcs_idx_nxt;
      upd_pend <= out_hs_c & (state != ST_FCS);
      if (upd_pend) crc_q <= crc_ret;
      fcs_done <= fcs_fire_c;
      if (fcs_fire_c) fcs_value <= ~bitrev32(crc_eff);
    end
  end
endmodule

// File: tb/tb_eth_fcs_sequencer.sv
// Randomized bench for eth_fcs_sequencer: two instances (MIN_LEN 0 and 60) share stimulus,
// one is observed at a time and checked against a byte-level reflected CRC-32 framing model.
module tb_eth_fcs_sequencer;
  typedef logic [7:0] byte_q_t[$];

  logic       clock = 1'b0;
  logic       reset;
  logic       sel;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       out_ready;

  eth_fcs_sequencer_if bus0 ();
  eth_fcs_sequencer_if bus60 ();

  assign bus0.in_data    = in_data;
  assign bus0.in_valid   = in_valid;
  assign bus0.in_last    = in_last;
  assign bus0.out_ready  = out_ready;
  assign bus60.in_data   = in_data;
  assign bus60.in_valid  = in_valid;
  assign bus60.in_last   = in_last;
  assign bus60.out_ready = out_ready;

  logic        busy0, busy60, done0, done60;
  logic [31:0] fcs0, fcs60;

  eth_fcs_sequencer #(.MIN_LEN(0), .CNT_W(11)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0),
    .busy(busy0), .fcs_value(fcs0), .fcs_done(done0)
  );

  eth_fcs_sequencer #(.MIN_LEN(60), .CNT_W(11)) dut60 (
    .clock(clock), .reset(reset), .bus(bus60),
    .busy(busy60), .fcs_value(fcs60), .fcs_done(done60)
  );

  logic        m_in_ready, m_out_valid, m_out_last, m_fcs_done, m_busy;
  logic [7:0]  m_out_data;
  logic [31:0] m_fcs_value;
  assign m_in_ready  = sel ? bus60.in_ready  : bus0.in_ready;
  assign m_out_valid = sel ? bus60.out_valid : bus0.out_valid;
  assign m_out_last  = sel ? bus60.out_last  : bus0.out_last;
  assign m_out_data  = sel ? bus60.out_data  : bus0.out_data;
  assign m_fcs_done  = sel ? done60 : done0;
  assign m_fcs_value = sel ? fcs60  : fcs0;
  assign m_busy      = sel ? busy60 : busy0;

  always #5 clock = ~clock;

  int          total;
  int          bad;
  int          cyc;
  int          ready_mode;
  logic        in_hs;
  byte_q_t     got_q, exp_q;
  logic        got_last_q[$], exp_last_q[$];
  int          got_cyc_q[$];
  logic [31:0] got_fcs_q[$], exp_fcs_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reflected CRC-32 register over a byte list (init all-ones, no final inversion).
  function automatic logic [31:0] ref_crc(input byte_q_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  function automatic byte_q_t rand_payload(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  function automatic byte_q_t ascii_123456789();
    byte_q_t q;
    for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
    return q;
  endfunction

  // One cycle: record output handshakes at the falling edge, then advance past the rising edge.
  task automatic tick();
    @(negedge clock);
    if (m_out_valid && out_ready) begin
      got_q.push_back(m_out_data);
      got_last_q.push_back(m_out_last);
      got_cyc_q.push_back(cyc);
    end
    if (m_fcs_done) got_fcs_q.push_back(m_fcs_value);
    in_hs = in_valid && m_in_ready;
    @(posedge clock);
    #1;
    cyc++;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic clear_q();
    got_q.delete(); got_last_q.delete(); got_cyc_q.delete(); got_fcs_q.delete();
    exp_q.delete(); exp_last_q.delete(); exp_fcs_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    clear_q();
  endtask

  // Expected wire image: payload, zero pad up to min_len, then ~crc least-significant byte first.
  task automatic expect_frame(input byte_q_t pl, input int min_len);
    byte_q_t     f;
    logic [31:0] fcs;
    f = pl;
    while (f.size() < min_len) f.push_back(8'h00);
    fcs = ~ref_crc(f);
    foreach (f[i]) begin
      exp_q.push_back(f[i]);
      exp_last_q.push_back(1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(8'(fcs >> (8 * k)));
      exp_last_q.push_back(k == 3);
    end
    exp_fcs_q.push_back(fcs);
  endtask

  task automatic send_payload(input byte_q_t pl, input int gap_idx, input int gap_len);
    int idx;
    int gapc;
    int budget;
    idx = 0; gapc = 0; budget = 0;
    while (idx < pl.size()) begin
      if (idx == gap_idx && gapc < gap_len) begin
        in_valid = 1'b0; in_last = 1'b0; gapc++;
      end else begin
        in_valid = 1'b1; in_data = pl[idx]; in_last = (idx == pl.size() - 1);
      end
      tick();
      if (in_hs) idx++;
      budget++;
      if (budget > 4000) begin
        check_eq("in_timeout", 32'(idx), 32'(pl.size()));
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic run_frame(input byte_q_t pl, input int gap_idx, input int gap_len);
    expect_frame(pl, sel ? 60 : 0);
    send_payload(pl, gap_idx, gap_len);
  endtask

  task automatic compare_stream(input string tag);
    int budget;
    int n;
    int mi;
    budget = 0;
    while ((got_q.size() < exp_q.size() || got_fcs_q.size() < exp_fcs_q.size()) && budget < 3000) begin
      tick();
      budget++;
    end
    repeat (3) tick();
    check_eq({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    mi = n - 1;
    for (int i = 0; i < n; i++) begin
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
        mi = i;
        break;
      end
    end
    if (n > 0)
      check_eq($sformatf("%s_byte%0d", tag, mi), {23'h0, got_last_q[mi], got_q[mi]},
               {23'h0, exp_last_q[mi], exp_q[mi]});
    check_eq({tag, "_nfcs"}, 32'(got_fcs_q.size()), 32'(exp_fcs_q.size()));
    for (int i = 0; i < got_fcs_q.size() && i < exp_fcs_q.size(); i++)
      check_eq($sformatf("%s_fcs%0d", tag, i), got_fcs_q[i], exp_fcs_q[i]);
  endtask

  initial begin
    byte_q_t pl;
    int      idx;
    int      budget;
    total = 0; bad = 0; cyc = 0; ready_mode = 0; in_hs = 1'b0;
    reset = 1'b1; sel = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    @(negedge clock);
    check_eq("rst_busy0", 32'(busy0), 32'd0);
    check_eq("rst_busy60", 32'(busy60), 32'd0);
    check_eq("rst_valid0", 32'(bus0.out_valid), 32'd0);
    check_eq("rst_valid60", 32'(bus60.out_valid), 32'd0);
    check_eq("rst_done0", 32'(done0), 32'd0);
    check_eq("rst_fcs60", fcs60, 32'd0);
    check_eq("rst_ready0", 32'(bus0.in_ready), 32'd1);
    @(posedge clock);
    #1;

    // Check value frame, then the same frame under a 1/0 ready pattern.
    ready_mode = 0;
    run_frame(ascii_123456789(), -1, 0);
    compare_stream("t1_check");
    check_eq("t1_fcs_const", m_fcs_value, 32'hCBF4_3926);
    clear_q();
    ready_mode = 1;
    run_frame(ascii_123456789(), -1, 0);
    compare_stream("t2_toggle");
    check_eq("t2_fcs_const", m_fcs_value, 32'hCBF4_3926);
    clear_q();

    // Mid-frame idle gap must not disturb the CRC.
    ready_mode = 0;
    run_frame(rand_payload(30), 12, 5);
    compare_stream("t6_gap0");
    clear_q();

    ready_mode = 2;
    for (int f = 0; f < 6; f++) begin
      run_frame(rand_payload($urandom_range(1, 70)), $urandom_range(0, 20), $urandom_range(0, 4));
      compare_stream($sformatf("rnd0_%0d", f));
      clear_q();
    end

    // Reset while payload byte 20 of a 64-byte frame is due.
    do_reset();
    ready_mode = 0; out_ready = 1'b1;
    pl = rand_payload(64);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(pl[i]);
      exp_last_q.push_back(1'b0);
    end
    idx = 0; budget = 0;
    while (idx < 20 && budget < 200) begin
      in_valid = 1'b1; in_data = pl[idx]; in_last = 1'b0;
      tick();
      if (in_hs) idx++;
      budget++;
    end
    reset = 1'b1; in_valid = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check_eq("t5_busy", 32'(m_busy), 32'd0);
    check_eq("t5_valid", 32'(m_out_valid), 32'd0);
    @(posedge clock);
    #1;
    compare_stream("t5_abort");
    clear_q();
    run_frame(ascii_123456789(), -1, 0);
    compare_stream("t5_after");
    check_eq("t5_fcs_const", m_fcs_value, 32'hCBF4_3926);

    // Padded instance from here on.
    do_reset();
    sel = 1'b1;
    ready_mode = 0;
    run_frame(rand_payload(14), -1, 0);
    compare_stream("t3_pad");
    check_eq("t3_total", 32'(got_q.size()), 32'd64);
    check_eq("t3_residue", rev32(ref_crc(got_q)), 32'hC704_DD7B);
    clear_q();

    run_frame(rand_payload(1), -1, 0);
    run_frame(rand_payload(60), -1, 0);
    compare_stream("t4_b2b");
    if (got_cyc_q.size() >= 128)
      check_eq("t4_fcs_gap", 32'(got_cyc_q[124] - got_cyc_q[123]), 32'd1);
    else
      check_eq("t4_size", 32'(got_cyc_q.size()), 32'd128);
    clear_q();

    ready_mode = 2;
    run_frame(rand_payload(40), 20, 5);
    compare_stream("t6_gap60");
    clear_q();
    for (int f = 0; f < 3; f++) begin
      run_frame(rand_payload(59 + f), -1, 0);
      compare_stream($sformatf("edge60_%0d", f));
      clear_q();
    end
    for (int f = 0; f < 6; f++) begin
      run_frame(rand_payload($urandom_range(1, 90)), $urandom_range(0, 30), $urandom_range(0, 4));
      compare_stream($sformatf("rnd60_%0d", f));
      clear_q();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
